// File: rtl/rx_stream_merger_if.sv
// Handshake bundle between the FWFT input FIFOs, the round-robin merger and the
// shared downstream write port.
interface rx_stream_merger_if #(
    parameter int WIDTH = 4,
    parameter int DSIZE = 32
);
    logic [WIDTH-1:0]       IN_EMPTY;
    logic [WIDTH*DSIZE-1:0] IN_DATA;
    logic [WIDTH-1:0]       IN_READ;
    logic                   OUT_READY;
    logic                   OUT_WRITE;
    logic [DSIZE-1:0]       OUT_DATA;
    logic [2:0]             GRANT_ID;
    logic                   BUSY;

    modport master (
        output IN_EMPTY, IN_DATA, OUT_READY,
        input  IN_READ, OUT_WRITE, OUT_DATA, GRANT_ID, BUSY
    );

    modport slave (
        input  IN_EMPTY, IN_DATA, OUT_READY,
        output IN_READ, OUT_WRITE, OUT_DATA, GRANT_ID, BUSY
    );
endinterface

// File: rtl/rx_stream_merger.sv
// Round-robin merger of up to WIDTH FWFT FIFOs into one write stream, with at
// most MAX_BURST words per grant before the grant rotates.
module rx_stream_merger #(
    parameter int WIDTH     = 4,
    parameter int DSIZE     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic               BUS_CLK,
    input  logic               BUS_RST,
    rx_stream_merger_if.slave  bus
);
    // state | meaning
    // ARB   | dead cycle: pick next non-empty channel after the last grant
    // GRANT | stream words from the granted channel until empty or burst done
    typedef enum logic {ARB, GRANT} state_t;

    localparam int CW = $clog2(MAX_BURST) + 1;

    state_t           r_state;
    logic [2:0]       r_grant;
    logic [CW-1:0]    r_cnt;

    logic             w_found;
    logic [2:0]       w_pick;
    logic             w_sel_empty;
    logic [DSIZE-1:0] w_sel_data;
    logic             w_xfer;
    logic [WIDTH-1:0] w_read;

    // Scan last+1, last+2, ... so the most recent grant gets the lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant;
        for (int k = 1; k <= WIDTH; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_found && (i == (int'(r_grant) + k) % WIDTH) && !bus.IN_EMPTY[i]) begin
                    w_found = 1'b1;
                    w_pick  = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_data  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_empty = bus.IN_EMPTY[i];
                w_sel_data  = bus.IN_DATA[i*DSIZE +: DSIZE];
            end
        end
    end

    assign w_xfer = (r_state == GRANT) && !w_sel_empty && bus.OUT_READY;

    always_comb begin
        w_read = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_read[i] = w_xfer && (r_grant == 3'(i));
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state <= ARB;
            r_grant <= 3'(WIDTH - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_sel_empty || (w_xfer && (r_cnt == CW'(MAX_BURST - 1)))) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign bus.IN_READ   = w_read;
    assign bus.OUT_WRITE = w_xfer;
    assign bus.OUT_DATA  = w_sel_data;
    assign bus.GRANT_ID  = r_grant;
    assign bus.BUSY      = (r_state == GRANT);
endmodule

// File: tb/tb_rx_stream_merger.sv
// Bench for rx_stream_merger: queue-backed FWFT channel models, a per-cycle
// table for the basic sweep, and directed sequences for bursts, stalls and reset.
module tb_rx_stream_merger;
    localparam int W  = 4;
    localparam int DS = 32;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_stream_merger_if #(.WIDTH(W), .DSIZE(DS)) bus ();

    rx_stream_merger #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(MB)) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        ready;
        logic        wr;
        logic [2:0]  grant;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] q [W][$];
    int          seqn [W];
    logic [W-1:0] hide = '0;
    int n_push = 0;
    int n_wr   = 0;

    logic        s_wr, s_busy;
    logic [W-1:0] s_rd;
    logic [2:0]  s_grant;
    logic [31:0] s_data;

    int hist [$];
    int run_ch [$];
    int run_len [$];
    int run_start [$];

    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic wr, input int g, input logic b, input logic [31:0] d);
        vec_t v;
        v.ready = r;
        v.wr    = wr;
        v.grant = 3'(g);
        v.busy  = b;
        v.data  = d;
        return v;
    endfunction

    function automatic logic [31:0] front(input int ch);
        if (ch < W && q[ch].size() != 0) return q[ch][0];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic drive();
        for (int i = 0; i < W; i++) begin
            bus.IN_EMPTY[i]          = (q[i].size() == 0) || hide[i];
            bus.IN_DATA[i*DS +: DS]  = (q[i].size() != 0) ? q[i][0] : 32'h0;
        end
    endtask

    task automatic push(input int ch, input int n);
        for (int j = 0; j < n; j++) begin
            q[ch].push_back({8'(ch), 24'(seqn[ch])});
            seqn[ch]++;
            n_push++;
        end
        drive();
    endtask

    // Sample at the falling edge, then apply the sampled pops after the rising edge.
    task automatic cycle();
        logic [W-1:0] emp;
        @(negedge clk);
        s_wr    = bus.OUT_WRITE;
        s_rd    = bus.IN_READ;
        s_grant = bus.GRANT_ID;
        s_busy  = bus.BUSY;
        s_data  = bus.OUT_DATA;
        emp     = bus.IN_EMPTY;
        chk("rd_vs_wr", 64'(s_rd), s_wr ? 64'(W'(1) << s_grant) : 64'(0));
        chk("rd_when_empty", 64'(s_rd & emp), 64'(0));
        chk("wr_not_ready", 64'(s_wr & ~bus.OUT_READY), 64'(0));
        if (s_wr) begin
            chk("wr_data", s_data, front(int'(s_grant)));
            n_wr++;
        end
        hist.push_back(s_wr ? int'(s_grant) : -1);
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            if (s_rd[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_write", bus.OUT_WRITE, 0);
        chk("rst_read", bus.IN_READ, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_grant", bus.GRANT_ID, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic analyze();
        run_ch.delete();
        run_len.delete();
        run_start.delete();
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k] >= 0 && (k == 0 || hist[k-1] != hist[k])) begin
                run_ch.push_back(hist[k]);
                run_len.push_back(1);
                run_start.push_back(k);
            end else if (hist[k] >= 0) begin
                run_len[run_len.size()-1]++;
            end
        end
    endtask

    function automatic int rl(input int k);
        return (k < run_len.size()) ? run_len[k] : -1;
    endfunction
    function automatic int rc(input int k);
        return (k < run_ch.size()) ? run_ch[k] : -1;
    endfunction
    function automatic int gap(input int k);
        if (k + 1 < run_start.size()) return run_start[k+1] - (run_start[k] + run_len[k]);
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        for (int i = 0; i < W; i++) seqn[i] = 0;
        bus.OUT_READY = 1'b0;
        drive();

        // Sweep of four 3-word channels; one stall cycle in the ch1 burst.
        tbl[0]  = mk(1, 0, 3, 0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 1, 32'h0000_0000);
        tbl[2]  = mk(1, 1, 0, 1, 32'h0000_0001);
        tbl[3]  = mk(1, 1, 0, 1, 32'h0000_0002);
        tbl[4]  = mk(1, 0, 0, 1, 32'h0);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 1, 1, 1, 32'h0100_0000);
        tbl[7]  = mk(0, 0, 1, 1, 32'h0);
        tbl[8]  = mk(1, 1, 1, 1, 32'h0100_0001);
        tbl[9]  = mk(1, 1, 1, 1, 32'h0100_0002);
        tbl[10] = mk(1, 0, 1, 1, 32'h0);
        tbl[11] = mk(1, 0, 1, 0, 32'h0);
        tbl[12] = mk(1, 1, 2, 1, 32'h0200_0000);
        tbl[13] = mk(1, 1, 2, 1, 32'h0200_0001);
        tbl[14] = mk(1, 1, 2, 1, 32'h0200_0002);
        tbl[15] = mk(1, 0, 2, 1, 32'h0);
        tbl[16] = mk(1, 0, 2, 0, 32'h0);
        tbl[17] = mk(1, 1, 3, 1, 32'h0300_0000);
        tbl[18] = mk(1, 1, 3, 1, 32'h0300_0001);
        tbl[19] = mk(1, 1, 3, 1, 32'h0300_0002);
        tbl[20] = mk(1, 0, 3, 1, 32'h0);
        tbl[21] = mk(1, 0, 3, 0, 32'h0);

        for (int c = 0; c < W; c++) push(c, 3);
        do_reset();
        for (int v = 0; v < 22; v++) begin
            bus.OUT_READY = tbl[v].ready;
            cycle();
            chk($sformatf("t%0d_wr", v), s_wr, tbl[v].wr);
            chk($sformatf("t%0d_grant", v), s_grant, tbl[v].grant);
            chk($sformatf("t%0d_busy", v), s_busy, tbl[v].busy);
            if (tbl[v].wr) chk($sformatf("t%0d_data", v), s_data, tbl[v].data);
        end
        bus.OUT_READY = 1'b1;

        // One channel with 40 words: bursts 16,16,8 separated by one ARB cycle.
        hist.delete();
        base = n_wr;
        push(1, 40);
        repeat (50) cycle();
        analyze();
        chk("s2_nruns", run_len.size(), 3);
        chk("s2_len0", rl(0), 16);
        chk("s2_len1", rl(1), 16);
        chk("s2_len2", rl(2), 8);
        chk("s2_ch0", rc(0), 1);
        chk("s2_ch2", rc(2), 1);
        chk("s2_gap0", gap(0), 1);
        chk("s2_gap1", gap(1), 1);
        chk("s2_writes", n_wr - base, 40);

        // Two channels with 20 words each alternate 16/16/4/4.
        hist.delete();
        base = n_wr;
        push(0, 20);
        push(2, 20);
        do_reset();
        repeat (55) cycle();
        analyze();
        chk("s3_nruns", run_len.size(), 4);
        chk("s3_ch0", rc(0), 0);
        chk("s3_ch1", rc(1), 2);
        chk("s3_ch2", rc(2), 0);
        chk("s3_ch3", rc(3), 2);
        chk("s3_len0", rl(0), 16);
        chk("s3_len1", rl(1), 16);
        chk("s3_len2", rl(2), 4);
        chk("s3_len3", rl(3), 4);
        chk("s3_gap0", gap(0), 1);
        chk("s3_gap1", gap(1), 1);
        chk("s3_gap2", gap(2), 2);
        chk("s3_writes", n_wr - base, 40);

        // Five-cycle backpressure stall mid-burst.
        base = n_wr;
        push(1, 10);
        cnt = 0;
        while (n_wr - base < 3 && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk("s4_reach3", n_wr - base, 3);
        bus.OUT_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("s4_stall_wr", s_wr, 0);
            chk("s4_stall_rd", s_rd, 0);
            chk("s4_stall_busy", s_busy, 1);
            chk("s4_stall_grant", s_grant, 1);
        end
        bus.OUT_READY = 1'b1;
        repeat (20) cycle();
        chk("s4_writes", n_wr - base, 10);
        chk("s4_drained", q[1].size(), 0);

        // Reset while the third word of a ch2 burst is on the bus.
        base = n_wr;
        push(2, 10);
        cnt = 0;
        while (n_wr - base < 2 && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk("s5_reach2", n_wr - base, 2);
        push(1, 2);
        push(3, 2);
        #1;
        chk("s5_pre_wr", bus.OUT_WRITE, 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_wr", bus.OUT_WRITE, 0);
        chk("s5_rst_rd", bus.IN_READ, 0);
        cycle();
        rst = 1'b0;
        chk("s5_kept", q[2].size(), 8);
        cnt = 0;
        s_wr = 1'b0;
        while (!s_wr && cnt < 10) begin
            cycle();
            cnt++;
        end
        chk("s5_first_wr", s_wr, 1);
        chk("s5_first_grant", s_grant, 1);
        repeat (30) cycle();
        chk("s5_drained", q[1].size() + q[2].size() + q[3].size(), 0);

        // Random empties and backpressure; queue model checks order and counts.
        hist.delete();
        base = n_push - n_wr;
        for (int k = 0; k < 10000; k++) begin
            bus.OUT_READY = ($urandom_range(0, 9) < 7);
            hide = W'($urandom);
            if ($urandom_range(0, 4) == 0) push($urandom_range(0, W-1), $urandom_range(1, 2));
            drive();
            cycle();
        end
        hide = '0;
        bus.OUT_READY = 1'b1;
        drive();
        cnt = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && cnt < 8000) begin
            cycle();
            cnt++;
        end
        chk("s6_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        chk("s6_balance", n_push - n_wr, 0);
        chk("s6_prior_balance", base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
